ahb_lite_master_port: RTL and testbench

//  AHB-Lite initiator that turns a simple valid/ready command stream into single AHB-Lite transfers.
//  It is the master-side counterpart of the AHB_Cache/AHB_GPIO responders and drives an AHB_Bus m_* port.
//  It lets non-CPU requesters (DMA, debug loader, bench traffic) reach the data-side slaves.
//  The address and data phases are pipelined, giving 1 transfer/cycle at zero wait states.

---
 rtl/ahb_lite_master_port_if.sv | 53 +++++
 rtl/ahb_lite_master_port.sv | 152 +++++++++++++++
 tb/tb_ahb_lite_master_port.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_master_port_if
//  Description : Command/response stream plus AHB-Lite master signals for
//                ahb_lite_master_port. The master modport is the initiator
//                side; the slave modport is the requester + AHB responder side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_lite_master_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // command stream
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [1:0]            cmd_size;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    // response stream
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    // AHB-Lite master signals
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [1:0]            HTRANS;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_err, rsp_rdata,
        output HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_err, rsp_rdata,
        input  HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_master_port.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_master_port
//  Description : AHB-Lite initiator turning a valid/ready command stream into
//                single (NONSEQ/SINGLE) transfers. Address and data phases are
//                pipelined through two slots (AP, DP); a two-cycle ERROR
//                response parks any pending address phase and re-issues it.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_lite_master_port #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    ahb_lite_master_port_if.master bus
);

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_size_word     = 2'b10;

    // controller states: normal pipelining, or inside an ERROR response
    localparam logic [0:0] c_st_run = 1'b0;
    localparam logic [0:0] c_st_err = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;

    // address slot
    logic                  r_ap_valid;
    logic [ADDR_WIDTH-1:0] r_ap_addr;
    logic                  r_ap_write;
    logic [1:0]            r_ap_size;
    logic [DATA_WIDTH-1:0] r_ap_wdata;
    logic                  r_ap_held;
    // data slot
    logic                  r_dp_valid;
    logic                  r_dp_write;
    logic [DATA_WIDTH-1:0] r_hwdata;
    // response
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_err;
    logic                  w_err_enter;
    logic                  w_err_done;
    logic                  w_advance;
    logic                  w_complete;
    logic                  w_cmd_ready;
    logic                  w_accept;
    logic [1:0]            w_size_norm;

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state: enter ERR on the first (HREADY=0) error cycle, leave on the second
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: if (r_dp_valid && !bus.HREADY && bus.HRESP) w_state_nxt = c_st_err;
            c_st_err: if (bus.HREADY) w_state_nxt = c_st_run;
        endcase
    end

    // control outputs of the controller
    always_comb begin
        w_err       = (r_state == c_st_err);
        w_err_enter = (r_state == c_st_run) && r_dp_valid && !bus.HREADY && bus.HRESP;
        w_err_done  = w_err && bus.HREADY;
        w_advance   = (r_state == c_st_run) && bus.HREADY;
        w_complete  = r_dp_valid && bus.HREADY;
        w_cmd_ready = bus.HREADY && !w_err && !r_ap_held && !RST;
        w_accept    = bus.cmd_valid && w_cmd_ready;
        // size 3 has no meaning on this bus width; issue it as a word
        w_size_norm = (bus.cmd_size == 2'b11) ? c_size_word : bus.cmd_size;
    end

    // address/data slot pipeline and response capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ap_valid  <= 1'b0;
            r_ap_addr   <= '0;
            r_ap_write  <= 1'b0;
            r_ap_size   <= c_size_word;
            r_ap_wdata  <= '0;
            r_ap_held   <= 1'b0;
            r_dp_valid  <= 1'b0;
            r_dp_write  <= 1'b0;
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_complete) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= bus.HRESP;
                r_rsp_rdata <= r_dp_write ? '0 : bus.HRDATA;
            end
            // a pending address phase was not taken by the slave; keep it parked
            if (w_err_enter) begin
                r_ap_held <= r_ap_valid;
            end
            // second error cycle retires DP; the parked AP goes back on the bus
            if (w_err_done) begin
                r_dp_valid <= 1'b0;
                r_ap_held  <= 1'b0;
            end
            if (w_advance) begin
                r_dp_valid <= r_ap_valid;
                r_dp_write <= r_ap_write;
                if (r_ap_valid && r_ap_write) begin
                    r_hwdata <= r_ap_wdata;
                end
                if (w_accept) begin
                    r_ap_valid <= 1'b1;
                    r_ap_addr  <= bus.cmd_addr;
                    r_ap_write <= bus.cmd_write;
                    r_ap_size  <= w_size_norm;
                    r_ap_wdata <= bus.cmd_wdata;
                end else begin
                    r_ap_valid <= 1'b0;
                end
            end
        end
    end

    // HTRANS is suppressed to IDLE while an ERROR response is in progress
    assign bus.HTRANS    = (r_ap_valid && !w_err) ? c_htrans_nonseq : c_htrans_idle;
    assign bus.HADDR     = r_ap_addr;
    assign bus.HWRITE    = r_ap_write;
    assign bus.HSIZE     = {1'b0, r_ap_size};
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = r_hwdata;
    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lite_master_port
//  Description : Directed bench for ahb_lite_master_port with a behavioural
//                AHB-Lite slave and an in-order response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_lite_master_port;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam logic [31:0] BAD = 32'h0BAD_0BAD;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ahb_lite_master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ahb_lite_master_port #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .HPROT_VAL (4'b0011)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rsp = 0;
    int          wait_cfg = 0;
    rsp_t        rsp_q[$];
    logic [31:0] wr_q[$];

    // slave model state
    logic        s_act = 1'b0;
    logic        s_write = 1'b0;
    logic        s_err = 1'b0;
    logic        s_stage = 1'b0;
    logic [31:0] s_addr = '0;
    int          s_waits = 0;
    logic        n_ready;
    logic        n_resp;
    logic [31:0] n_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    // AHB slave: error region 0x9xxx, wait_cfg wait states on OKAY transfers
    initial begin : slave
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = BAD;
        forever begin
            @(negedge clk);
            n_ready = 1'b1;
            n_resp  = 1'b0;
            n_rdata = BAD;
            if (rst) begin
                s_act = 1'b0;
            end else begin
                if (s_act && bus.HREADY) begin
                    if (s_write && !s_err) begin
                        chk("wr_q_nonempty", 32'(wr_q.size() != 0), 32'd1);
                        if (wr_q.size() != 0) chk("hwdata", bus.HWDATA, wr_q.pop_front());
                    end
                    s_act = 1'b0;
                end
                if (bus.HREADY && bus.HTRANS == 2'b10) begin
                    s_act   = 1'b1;
                    s_addr  = bus.HADDR;
                    s_write = bus.HWRITE;
                    s_err   = (bus.HADDR[15:12] == 4'h9);
                    s_waits = wait_cfg;
                    s_stage = 1'b0;
                end
                if (s_act) begin
                    if (s_err) begin
                        n_resp  = 1'b1;
                        n_ready = s_stage;
                        s_stage = 1'b1;
                    end else if (s_waits > 0) begin
                        n_ready = 1'b0;
                        s_waits--;
                    end else if (!s_write) begin
                        n_rdata = rd_data(s_addr);
                    end
                end
            end
            @(posedge clk);
            #1;
            bus.HREADY = n_ready;
            bus.HRESP  = n_resp;
            bus.HRDATA = n_rdata;
        end
    end

    // response monitor / scoreboard pop
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    n_rsp++;
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic drive_cmd(input logic w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
        rsp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_size  = sz;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        e.err   = exp_err;
        e.rdata = w ? 32'h0 : exp_rd;
        rsp_q.push_back(e);
        if (w && !exp_err) wr_q.push_back(d);
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_htrans",    32'(bus.HTRANS),    32'd0);
        chk("rst_haddr",     bus.HADDR,          32'h0);
        chk("rst_hwrite",    32'(bus.HWRITE),    32'd0);
        chk("rst_hsize",     32'(bus.HSIZE),     32'd2);
        chk("rst_hwdata",    bus.HWDATA,         32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("hburst",        32'(bus.HBURST),    32'd0);
        chk("hprot",         32'(bus.HPROT),     32'd3);
        chk("hmastlock",     32'(bus.HMASTLOCK), 32'd0);
        resync();
        rst = 1'b0;

        // 1: single word write, zero wait states
        resync();
        drive_cmd(1'b1, 2'd2, 32'h8004, 32'h0000_00A5, 1'b0, 32'h0);
        wait_accept("t1");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t1_htrans", 32'(bus.HTRANS), 32'd2);
        chk("t1_hwrite", 32'(bus.HWRITE), 32'd1);
        chk("t1_haddr",  bus.HADDR,       32'h8004);
        chk("t1_hsize",  32'(bus.HSIZE),  32'd2);
        @(negedge clk);
        chk("t1_idle",   32'(bus.HTRANS), 32'd0);
        chk("t1_hwdata", bus.HWDATA,      32'h0000_00A5);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rsp_err",   32'(bus.rsp_err),   32'd0);

        // 2: word read with two wait states
        resync();
        wait_cfg = 2;
        drive_cmd(1'b0, 2'd2, 32'h0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_accept("t2");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t2_htrans", 32'(bus.HTRANS), 32'd2);
        chk("t2_haddr",  bus.HADDR,       32'h0010);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_wait_haddr",  bus.HADDR,          32'h0010);
            chk("t2_wait_hwdata", bus.HWDATA,         32'h0000_00A5);
            chk("t2_wait_rsp",    32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk("t2_rsp_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t2_rsp_rdata", bus.rsp_rdata,      32'hDEAD_BEEF);
        wait_cfg = 0;

        // 3: three back-to-back writes
        resync();
        drive_cmd(1'b1, 2'd2, 32'h0, 32'h1111_1111, 1'b0, 32'h0);
        @(negedge clk);
        chk("t3_rdy0", 32'(bus.cmd_ready), 32'd1);
        resync();
        drive_cmd(1'b1, 2'd2, 32'h4, 32'h2222_2222, 1'b0, 32'h0);
        @(negedge clk);
        chk("t3_htrans0", 32'(bus.HTRANS),    32'd2);
        chk("t3_haddr0",  bus.HADDR,          32'h0);
        chk("t3_rdy1",    32'(bus.cmd_ready), 32'd1);
        resync();
        drive_cmd(1'b1, 2'd2, 32'h8, 32'h3333_3333, 1'b0, 32'h0);
        @(negedge clk);
        chk("t3_htrans1", 32'(bus.HTRANS),    32'd2);
        chk("t3_haddr1",  bus.HADDR,          32'h4);
        chk("t3_rdy2",    32'(bus.cmd_ready), 32'd1);
        resync();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t3_htrans2", 32'(bus.HTRANS), 32'd2);
        chk("t3_haddr2",  bus.HADDR,       32'h8);
        chk("t3_rsp0",    32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        chk("t3_rsp1", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        chk("t3_rsp2", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        chk("t3_rsp_end", 32'(bus.rsp_valid), 32'd0);

        // 4: ERROR on read 0x9000 with read 0x0020 pending in the address slot
        resync();
        drive_cmd(1'b0, 2'd2, 32'h9000, 32'h0, 1'b1, BAD);
        wait_accept("t4a");
        drive_cmd(1'b0, 2'd2, 32'h0020, 32'h0, 1'b0, rd_data(32'h0020));
        @(negedge clk);
        chk("t4_htrans_a", 32'(bus.HTRANS),    32'd2);
        chk("t4_haddr_a",  bus.HADDR,          32'h9000);
        chk("t4_rdy_b",    32'(bus.cmd_ready), 32'd1);
        resync();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t4_err1_htrans", 32'(bus.HTRANS),    32'd2);
        chk("t4_err1_haddr",  bus.HADDR,          32'h0020);
        chk("t4_err1_rdy",    32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        chk("t4_err2_htrans", 32'(bus.HTRANS),    32'd0);
        chk("t4_err2_rdy",    32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        chk("t4_rsp_err_v",   32'(bus.rsp_valid), 32'd1);
        chk("t4_rsp_err",     32'(bus.rsp_err),   32'd1);
        chk("t4_reissue",     32'(bus.HTRANS),    32'd2);
        chk("t4_reissue_a",   bus.HADDR,          32'h0020);
        @(negedge clk);
        @(negedge clk);
        chk("t4_rsp_ok_v",    32'(bus.rsp_valid), 32'd1);
        chk("t4_rsp_ok_err",  32'(bus.rsp_err),   32'd0);

        // 5: byte write to an odd address
        resync();
        drive_cmd(1'b1, 2'd0, 32'h8001, 32'h0000_5A00, 1'b0, 32'h0);
        wait_accept("t5");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_htrans", 32'(bus.HTRANS), 32'd2);
        chk("t5_hsize",  32'(bus.HSIZE),  32'd0);
        chk("t5_haddr",  bus.HADDR,       32'h8001);

        // 6: reset in the middle of a waited data phase with an AP pending
        repeat (4) @(posedge clk);
        #1;
        wait_cfg = 3;
        drive_cmd(1'b0, 2'd2, 32'h0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_accept("t6a");
        drive_cmd(1'b1, 2'd2, 32'h0040, 32'h0000_0077, 1'b0, 32'h0);
        @(negedge clk);
        chk("t6_rdy_b", 32'(bus.cmd_ready), 32'd1);
        resync();
        @(negedge clk);
        chk("t6_ap_held", 32'(bus.HTRANS), 32'd2);
        chk("t6_haddr",   bus.HADDR,       32'h0040);
        #2 rst = 1'b1;
        rsp_q.delete();
        wr_q.delete();
        wait_cfg = 0;
        #1;
        chk("t6_rst_htrans", 32'(bus.HTRANS),    32'd0);
        chk("t6_rst_rdy",    32'(bus.cmd_ready), 32'd0);
        chk("t6_rst_rsp",    32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_rst_hold_rdy", 32'(bus.cmd_ready), 32'd0);
            chk("t6_rst_hold_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        resync();
        resync();
        drive_cmd(1'b1, 2'd2, 32'h8008, 32'hCAFE_F00D, 1'b0, 32'h0);
        wait_accept("t6b");
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t6b_htrans", 32'(bus.HTRANS), 32'd2);
        chk("t6b_haddr",  bus.HADDR,       32'h8008);

        // drain
        begin
            int n = 0;
            while (rsp_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (2) @(negedge clk);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("wr_q_drained",  32'(wr_q.size()),  32'd0);
        chk("rsp_count",     32'(n_rsp),        32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
